// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's data-memory port.
// Serves word accesses from an internal array with registered 1-cycle read
// data. After reset the array is zero-filled by a scrub state machine, and
// ready_o rises on the edge that writes the last word.
// Optional build macro DMEM_MMIO_EN adds MMIO words at 0xFFFFFFF0..0xFFFFFFFC:
// a tohost mailbox (F0) and a free-running READY-cycle counter (F4).
module dmem_resp #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_din_i,
  input  logic [31:0] dm_wen_i,
  output logic [31:0] dm_dout_o,
  output logic        ready_o,
  output logic        err_o,
  output logic [31:0] tohost_o,
  output logic        tohost_vld_o
);

  localparam logic [0:0] SCRUB = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [31:0]   mem [DEPTH];
  logic [0:0]    state;
  logic [AW-1:0] ptr;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          mmio;
  logic          any_wen;
  logic [31:0]   merged;
  logic [31:0]   mmio_rd;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  // Byte-lane bits of the address carry no meaning for a word array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dm_addr_i[1:0];

  // Address decode and masked write-data merge for the current access.
  always_comb begin
    idx      = dm_addr_i[AW+1:2];
    in_range = (dm_addr_i[31:AW+2] == {(30-AW){1'b0}});
`ifdef DMEM_MMIO_EN
    mmio     = (dm_addr_i[31:4] == 28'hFFF_FFFF);
`else
    mmio     = 1'b0;
`endif
    any_wen  = (dm_wen_i != 32'h0000_0000);
    merged   = (mem[idx] & ~dm_wen_i) | (dm_din_i & dm_wen_i);
  end

  // Single array write port: scrub zero-fill takes it in SCRUB, the core in READY.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = 32'h0000_0000;
    if (!rst_n_i) begin
      wr_en = 1'b0;
    end else if (state == SCRUB) begin
      wr_en   = 1'b1;
      wr_addr = ptr;
      wr_data = 32'h0000_0000;
    end else if (in_range && any_wen) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = merged;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Read data source; out-of-range and ignored MMIO words read as zero.
  always_comb begin
    if (in_range) begin
      rd_data = mem[idx];
    end else if (mmio) begin
      rd_data = mmio_rd;
    end else begin
      rd_data = 32'h0000_0000;
    end
  end

  // Array storage; contents are not reset, scrub clears them.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scrub/ready state machine, registered read data and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= SCRUB;
      ptr       <= {AW{1'b0}};
      dm_dout_o <= 32'h0000_0000;
      ready_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        SCRUB: begin
          dm_dout_o <= 32'h0000_0000;
          ptr       <= ptr + {{(AW-1){1'b0}}, 1'b1};
          if (ptr == {AW{1'b1}}) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        READY: begin
          dm_dout_o <= rd_data;
          if (!in_range && !mmio) begin
            err_o <= 1'b1;
          end
        end
        default: begin
          state   <= SCRUB;
          ptr     <= {AW{1'b0}};
          ready_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] cycle_cnt;

  // MMIO read mux: tohost, cycle counter, two reserved zero words.
  always_comb begin
    case (dm_addr_i[3:2])
      2'b00:   mmio_rd = tohost_o;
      2'b01:   mmio_rd = cycle_cnt;
      default: mmio_rd = 32'h0000_0000;
    endcase
  end

  // READY-cycle counter and tohost mailbox with a one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cycle_cnt    <= 32'h0000_0000;
      tohost_o     <= 32'h0000_0000;
      tohost_vld_o <= 1'b0;
    end else begin
      tohost_vld_o <= 1'b0;
      if (state == READY) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (mmio && (dm_addr_i[3:2] == 2'b00) && any_wen) begin
          tohost_o     <= (tohost_o & ~dm_wen_i) | (dm_din_i & dm_wen_i);
          tohost_vld_o <= 1'b1;
        end
      end
    end
  end
`else
  assign mmio_rd      = 32'h0000_0000;
  assign tohost_o     = 32'h0000_0000;
  assign tohost_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp (DEPTH=64). Inputs change 1ns
// after each rising edge; outputs are sampled 1ns after the edge that
// registers them, so dout after cyc(a,...) holds the read of address a.
// Build with +define+DMEM_MMIO_EN to exercise the MMIO words.
module tb_dmem_resp;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] wen;
  logic [31:0] dout;
  logic        ready;
  logic        err;
  logic [31:0] tohost;
  logic        tohost_vld;

  int checks;
  int errors;
  int n;
  logic [31:0] c1;
  logic [31:0] c2;

  dmem_resp #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dm_addr_i    (addr),
    .dm_din_i     (din),
    .dm_wen_i     (wen),
    .dm_dout_o    (dout),
    .ready_o      (ready),
    .err_o        (err),
    .tohost_o     (tohost),
    .tohost_vld_o (tohost_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one access, let one rising edge pass, land 1ns after it.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [31:0] w);
    addr = a;
    din  = d;
    wen  = w;
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready_o rises, bounded; scrub-time accesses are hostile.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      cyc(32'h0000_0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cnt++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    addr   = 32'h0;
    din    = 32'h0;
    wen    = 32'h0;
    @(posedge clk);
    #1;
    cyc(32'h0, 32'h0, 32'h0);

    // Reset state
    check("rst_dout",   dout, 32'h0);
    check("rst_ready",  {31'd0, ready}, 32'h0);
    check("rst_err",    {31'd0, err}, 32'h0);
    check("rst_tohost", tohost, 32'h0);
    check("rst_vld",    {31'd0, tohost_vld}, 32'h0);

    // Scrub lasts exactly DEPTH cycles; accesses during it are ignored
    rst_n = 1'b1;
    wait_ready(n);
    check("scrub_len",  n, DEPTH);
    check("scrub_err",  {31'd0, err}, 32'h0);
    check("scrub_dout", dout, 32'h0);

    // Every word reads zero after scrub
    for (int i = 0; i < DEPTH; i++) begin
      cyc(i * 4, 32'h0, 32'h0);
      check("scrub_zero", dout, 32'h0);
    end

    // Full then lower-half masked write to 0x40
    cyc(32'h40, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check("w40_old", dout, 32'h0);
    cyc(32'h40, 32'h1234_5678, 32'h0000_FFFF);
    check("w40_rbw", dout, 32'hDEAD_BEEF);
    cyc(32'h40, 32'h0, 32'h0);
    check("w40_merge", dout, 32'hDEAD_5678);

    // Read-before-write, then back-to-back read of new data
    cyc(32'h8, 32'h1, 32'hFFFF_FFFF);
    cyc(32'h8, 32'h2, 32'hFFFF_FFFF);
    check("rbw_old", dout, 32'h1);
    cyc(32'h8, 32'h0, 32'h0);
    check("rbw_new", dout, 32'h2);

    // Highest in-range word
    cyc(32'hFC, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    cyc(32'hFC, 32'h0, 32'h0);
    check("top_word", dout, 32'hCAFE_F00D);
    check("no_err_yet", {31'd0, err}, 32'h0);

    // Out-of-range write (aliases word 0 in low bits) is dropped and sticks err
    cyc(32'h0001_0000, 32'h5555_5555, 32'hFFFF_FFFF);
    check("oor_dout", dout, 32'h0);
    check("oor_err",  {31'd0, err}, 32'h1);
    cyc(32'h0, 32'h0, 32'h0);
    check("oor_nowrite", dout, 32'h0);
    check("oor_sticky",  {31'd0, err}, 32'h1);
    cyc(32'h40, 32'h0, 32'h0);
    check("oor_keep40", dout, 32'hDEAD_5678);

    // Mid-traffic reset: write 0xAA to 0x0, one reset cycle, rescrub
    cyc(32'h0, 32'hAA, 32'hFFFF_FFFF);
    cyc(32'h0, 32'h0, 32'h0);
    check("aa_written", dout, 32'hAA);
    rst_n = 1'b0;
    cyc(32'h0, 32'h0, 32'h0);
    check("rst2_ready", {31'd0, ready}, 32'h0);
    check("rst2_err",   {31'd0, err}, 32'h0);
    check("rst2_dout",  dout, 32'h0);
    rst_n = 1'b1;
    wait_ready(n);
    check("rescrub_len", n, DEPTH);
    cyc(32'h0, 32'h0, 32'h0);
    check("rescrub_w0", dout, 32'h0);
    cyc(32'h40, 32'h0, 32'h0);
    check("rescrub_w40", dout, 32'h0);
    check("rescrub_err", {31'd0, err}, 32'h0);

`ifdef DMEM_MMIO_EN
    // tohost write: merged value, single valid pulse
    cyc(32'hFFFF_FFF0, 32'h1, 32'hFFFF_FFFF);
    check("th_val",  tohost, 32'h1);
    check("th_vld1", {31'd0, tohost_vld}, 32'h1);
    cyc(32'hFFFF_FFF0, 32'h0, 32'h0);
    check("th_vld0", {31'd0, tohost_vld}, 32'h0);
    check("th_read", dout, 32'h1);
    // Counter reads five cycles apart differ by five
    cyc(32'hFFFF_FFF4, 32'h0, 32'h0);
    c1 = dout;
    cyc(32'h0, 32'h0, 32'h0);
    cyc(32'h0, 32'h0, 32'h0);
    cyc(32'h0, 32'h0, 32'h0);
    cyc(32'h0, 32'h0, 32'h0);
    cyc(32'hFFFF_FFF4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    c2 = dout;
    check("cnt_delta", c2 - c1, 32'd5);
    cyc(32'hFFFF_FFF8, 32'h1234_5678, 32'hFFFF_FFFF);
    cyc(32'hFFFF_FFF8, 32'h0, 32'h0);
    check("rsvd_read", dout, 32'h0);
    check("mmio_noerr", {31'd0, err}, 32'h0);
    check("th_unchanged", tohost, 32'h1);
`else
    // Without MMIO, the tohost address is simply out of range
    cyc(32'hFFFF_FFF0, 32'h1, 32'hFFFF_FFFF);
    check("nommio_dout",   dout, 32'h0);
    check("nommio_err",    {31'd0, err}, 32'h1);
    check("nommio_tohost", tohost, 32'h0);
    check("nommio_vld",    {31'd0, tohost_vld}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
